// File: rtl/apb_slave_bridge.sv
// apb_slave_bridge: APB4 slave front-end that turns each APB transfer into a
// held request/acknowledge handshake on a generic peripheral back-end.
// All back-end and APB response signals come straight from flops.
// Optional feature: define APB_SLV_TIMEOUT_EN to abort a back-end request that
// is not acknowledged within TIMEOUT_CYCLES cycles (answered with pslverr=1).
module apb_slave_bridge #(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 12,
  parameter int unsigned ADDR_LIMIT     = 'h100,
  parameter int          TIMEOUT_CYCLES = 16,
  localparam int         STRB_W         = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              irq,
  output logic              dev_req,
  output logic              dev_we,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  output logic [STRB_W-1:0] dev_strb,
  input  logic              dev_ack,
  input  logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_err,
  input  logic              dev_irq
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RESP} state_t;

  // Byte addresses at or above the limit are rejected; alignment is to one
  // full data word, so the low address bits covered by the strobes must be 0.
  localparam longint unsigned   LIMIT      = 64'(ADDR_LIMIT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                req_q, req_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                irq_q, irq_d;
  logic                latch_req;
  logic                decode_err;

`ifdef APB_SLV_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0]          cnt_q, cnt_d;
`else
  logic [7:0]          timeout_unused;
  assign timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

  assign decode_err = (64'(addr_q) >= LIMIT) || ((addr_q & ALIGN_MASK) != '0);

  // Next-state logic: APB phase tracking, address decode, back-end handshake
  // and response formation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    req_d     = req_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    irq_d     = dev_irq;
    latch_req = 1'b0;
`ifdef APB_SLV_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d   = SETUP;
          latch_req = 1'b1;
        end
      end

      SETUP: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (!penable) begin
          latch_req = 1'b1;
        end else if (decode_err) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
`ifdef APB_SLV_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end

      REQ: begin
        if (dev_ack) begin
          state_d   = RESP;
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = dev_err;
          prdata_d  = (!we_q && !dev_err) ? dev_rdata : '0;
        end
`ifdef APB_SLV_TIMEOUT_EN
        else if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          state_d   = RESP;
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      RESP: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (latch_req) begin
      addr_d  = paddr;
      we_d    = pwrite;
      wdata_d = pwdata;
      strb_d  = pwrite ? pstrb : '1;
    end
  end

  // State and output registers; reset clears everything at once so an
  // in-flight request or response is dropped without completing.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      req_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      irq_q     <= 1'b0;
`ifdef APB_SLV_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      req_q     <= req_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      irq_q     <= irq_d;
`ifdef APB_SLV_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign irq       = irq_q;
  assign dev_req   = req_q;
  assign dev_we    = we_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_strb  = strb_q;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// tb_apb_slave_bridge: directed and randomized APB transfers against a
// transaction-level reference model of the bridge's response timing/values.
module tb_apb_slave_bridge;

  localparam int TO_CYC = 4;
`ifdef APB_SLV_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;
  logic        dev_req, dev_we;
  logic [11:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_strb;
  logic        dev_ack;
  logic [31:0] dev_rdata;
  logic        dev_err;
  logic        dev_irq;

  int total = 0;
  int bad   = 0;

  apb_slave_bridge #(
    .DATA_W(32), .ADDR_W(12), .ADDR_LIMIT('h100), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .irq(irq),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_strb(dev_strb), .dev_ack(dev_ack),
    .dev_rdata(dev_rdata), .dev_err(dev_err), .dev_irq(dev_irq)
  );

  always #5 pclk = ~pclk;

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: cycle (relative to c0) of pready, number of dev_req
  // cycles and the response contents, from the bridge's transaction rules.
  function automatic void refModel(input int addr, input bit wr, input logic [3:0] strb,
                                   input int delay, input bit err, input logic [31:0] rdata,
                                   input int budget,
                                   output int e_ready, output int e_reqs, output logic e_err,
                                   output logic [31:0] e_rdata, output logic [3:0] e_strb);
    e_strb = wr ? strb : 4'hF;
    if (addr >= 'h100 || (addr % 4) != 0) begin
      e_ready = 2; e_reqs = 0; e_err = 1'b1; e_rdata = 32'h0;
    end else if (TIMEOUT_EN && delay >= TO_CYC) begin
      e_ready = 2 + TO_CYC; e_reqs = TO_CYC; e_err = 1'b1; e_rdata = 32'h0;
    end else if (3 + delay > budget + 1) begin
      e_ready = -1; e_reqs = budget; e_err = 1'b0; e_rdata = 32'h0;
    end else begin
      e_ready = 3 + delay; e_reqs = delay + 1; e_err = err;
      e_rdata = (!wr && !err) ? rdata : 32'h0;
    end
  endfunction

  // Drives one APB transfer starting at the next cycle and plays a back-end
  // that acknowledges on the (delay+1)-th cycle of dev_req. Returns when
  // pready is seen (psel/penable left high) or the cycle budget runs out.
  task automatic applyStimulus(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int delay, input logic err,
                               input logic [31:0] rdata, input int budget,
                               output int ready_cyc, output int reqs, output logic got_err,
                               output logic [31:0] got_rdata, output logic [11:0] got_addr,
                               output logic got_we, output logic [31:0] got_wdata,
                               output logic [3:0] got_strb, output logic early);
    int cyc;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    dev_ack = 1'b0; dev_err = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    early = dev_req | pready;
    ready_cyc = -1; reqs = 0; cyc = 1;
    got_err = 1'b0; got_rdata = 32'h0; got_addr = 12'h0; got_we = 1'b0;
    got_wdata = 32'h0; got_strb = 4'h0;
    while (ready_cyc < 0 && cyc < budget + 1) begin
      @(posedge pclk); #1;
      cyc++;
      dev_ack = 1'b0; dev_err = 1'b0; dev_rdata = $urandom;
      if (dev_req) begin
        if (reqs == 0) begin
          got_addr = dev_addr; got_we = dev_we; got_wdata = dev_wdata; got_strb = dev_strb;
        end
        reqs++;
        if (reqs == delay + 1) begin
          dev_ack = 1'b1; dev_err = err; dev_rdata = rdata;
        end
      end
      if (pready) begin
        ready_cyc = cyc; got_err = pslverr; got_rdata = prdata;
      end
    end
    dev_ack = 1'b0;
  endtask

  // Full transfer plus comparison of every observed item with the model.
  task automatic runTransfer(input string tag, input int addr, input bit wr,
                             input logic [31:0] wdata, input logic [3:0] strb, input int delay,
                             input bit err, input logic [31:0] rdata, input int budget);
    int r_cyc, r_reqs, e_ready, e_reqs;
    logic r_err, r_we, r_early, e_err;
    logic [31:0] r_rdata, r_wdata, e_rdata;
    logic [11:0] r_addr;
    logic [3:0]  r_strb, e_strb;
    applyStimulus(addr[11:0], wr, wdata, strb, delay, err, rdata, budget,
                  r_cyc, r_reqs, r_err, r_rdata, r_addr, r_we, r_wdata, r_strb, r_early);
    refModel(addr, wr, strb, delay, err, rdata, budget, e_ready, e_reqs, e_err, e_rdata, e_strb);
    checkOutput({tag, ".c1_quiet"}, 64'(r_early), 64'(0));
    checkOutput({tag, ".ready_cycle"}, 64'(r_cyc), 64'(e_ready));
    checkOutput({tag, ".req_cycles"}, 64'(r_reqs), 64'(e_reqs));
    if (e_ready >= 0) begin
      checkOutput({tag, ".pslverr"}, 64'(r_err), 64'(e_err));
      checkOutput({tag, ".prdata"}, 64'(r_rdata), 64'(e_rdata));
    end
    if (e_reqs > 0) begin
      checkOutput({tag, ".dev_addr"}, 64'(r_addr), 64'(addr[11:0]));
      checkOutput({tag, ".dev_we"}, 64'(r_we), 64'(wr));
      checkOutput({tag, ".dev_wdata"}, 64'(r_wdata), 64'(wdata));
      checkOutput({tag, ".dev_strb"}, 64'(r_strb), 64'(e_strb));
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  initial begin
    int addr, delay;
    bit wr, err;
    logic seen;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0;
    pwdata = 32'h0; pstrb = 4'h0; dev_ack = 1'b0; dev_rdata = 32'h0; dev_err = 1'b0;
    dev_irq = 1'b0;
    $display("[TB] start");

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset.ctrl", 64'({pready, pslverr, irq, dev_req, dev_we}), 64'(0));
    checkOutput("reset.prdata", 64'(prdata), 64'(0));
    checkOutput("reset.dev_bus", 64'({dev_addr, dev_strb, dev_wdata}), 64'(0));
    preset = 1'b0;
    idleCycles(2);

    // Directed transfers
    runTransfer("wr_zero_wait", 'h010, 1'b1, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0, 200);
    idleCycles(1);
    runTransfer("rd_delay3", 'h020, 1'b0, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 200);
    idleCycles(1);
    runTransfer("rd_bad_0x102", 'h102, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222, 200);
    runTransfer("wr_dev_err", 'h04C, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 200);
    runTransfer("rd_b2b", 'h050, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1234_5678, 200);
    runTransfer("wr_strb0", 'h0FC, 1'b1, 32'hCAFE_0001, 4'h0, 2, 1'b0, 32'h0, 200);
    runTransfer("rd_limit_0x100", 'h100, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA, 200);
    runTransfer("wr_misalign", 'h011, 1'b1, 32'h7777_7777, 4'hF, 0, 1'b0, 32'h0, 200);
    runTransfer("rd_err", 'h000, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'hFFFF_0000, 200);
    idleCycles(2);

    // Randomized transfers, random idle gaps (0 gives back-to-back)
    for (int i = 0; i < 14; i++) begin
      addr = $urandom_range(0, 'h13F);
      if ($urandom_range(0, 3) != 0) addr = addr & ~3;
      wr = 1'($urandom_range(0, 1));
      delay = $urandom_range(0, 3);
      err = ($urandom_range(0, 3) == 0);
      runTransfer($sformatf("rnd%0d", i), addr, wr, $urandom, 4'($urandom), delay, err,
                  $urandom, 200);
      idleCycles($urandom_range(0, 2));
    end
    idleCycles(1);

    // Back-end never acknowledges: times out, or hangs for the whole budget
    runTransfer("no_ack", 'h040, 1'b0, 32'h0, 4'h0, 100000, 1'b0, 32'h0, 100);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    idleCycles(1);

    // irq is a one-cycle delayed copy of dev_irq
    dev_irq = 1'b1;
    #1;
    checkOutput("irq.lag", 64'(irq), 64'(0));
    @(posedge pclk); #1;
    checkOutput("irq.set", 64'(irq), 64'(1));

    // Reset in the middle of a back-end request
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    checkOutput("rst_mid.req_before", 64'(dev_req), 64'(1));
    preset = 1'b1;
    #1;
    checkOutput("rst_mid.outputs", 64'({dev_req, pready, irq}), 64'(0));
    checkOutput("rst_mid.prdata", 64'(prdata), 64'(0));
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; dev_irq = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge pclk); #1;
      seen = seen | pready | dev_req;
    end
    checkOutput("rst_mid.no_resp", 64'(seen), 64'(0));
    runTransfer("after_reset", 'h030, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h600D_D00D, 200);
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
